t_reg_context_stack: RTL and testbench
======================================

# t_reg_context_stack

Hardware save/restore engine for the temporary registers $8–$15. It is the producer side of the register file's bulk port: it samples `tRegistersIn`, and it drives `tRegistersOut` and `TRCWrite`. On `Save` it snapshots all eight t-registers and stores them as one frame in an internal 32-bit-wide word RAM. On `Restore` it pops the newest frame and writes it back to the register file in a single `TRCWrite` cycle. The block sits beside the register file in the ID stage and is driven by the control unit on call/return.

## Interface
Parameters:
- DEPTH, 4, number of 256-bit frames the stack holds (power of two, ≥2)
- DW, 32, word width of storage RAM and register file entries

Ports:
- Clk  in  1  single clock; all state changes on posedge
- Reset  in  1  synchronous, active-high
- Save  in  1  request: push current t-registers
- Restore  in  1  request: pop newest frame into t-registers
- tRegistersIn  in  256  live $8..$15 from register file, [255:224]=$8 … [31:0]=$15
- tRegistersOut  out  256  frame driven to register file, same packing
- TRCWrite  out  1  one-cycle write strobe to register file
- Busy  out  1  engine active; control must stall issue while high
- Depth  out  $clog2(DEPTH+1)  frames currently stored
- Full  out  1  Depth == DEPTH
- Empty  out  1  Depth == 0
- Overflow  out  1  sticky: Save requested while Full
- Underflow  out  1  sticky: Restore requested while Empty

## Operation
- States: IDLE, SAVE, RD_FILL, WRITEBACK (plus CLEAR, see Configuration).
- Requests are sampled only in IDLE. While Busy is high, requests are ignored without any flag being set.
- Save and Restore asserted together in IDLE: Save is accepted and Restore is dropped.
- IDLE + Save, not Full:
  - Latch `tRegistersIn` into the 256-bit snapshot register.
  - Go to SAVE and write words 0..7 to RAM address {wr_frame, k}, one word per cycle. Word k is bits [255-32k -: 32].
  - Depth increments on the edge that writes word 7, then return to IDLE.
- IDLE + Save, Full: set Overflow, stay in IDLE, stack unchanged.
- IDLE + Restore, not Empty:
  - Go to RD_FILL.
  - Issue addresses {Depth-1, k} for k = 0..7. The RAM read is registered (1-cycle latency).
  - Returned words shift into the assembly register.
  - After word 7 lands, go to WRITEBACK. Drive `tRegistersOut` = assembled frame with TRCWrite = 1 for exactly one cycle, then return to IDLE.
  - Depth decrements on the WRITEBACK edge.
- IDLE + Restore, Empty: set Underflow, stay in IDLE.
- Overflow and Underflow clear only on Reset.
- Ordinary `RegWrite` to $8–$15 during SAVE does not corrupt the frame, because the snapshot is taken at acceptance.
- `tRegistersOut` holds its last value outside WRITEBACK. It is only meaningful while TRCWrite = 1.
- Frame index arithmetic is modulo DEPTH. Depth is saturating and never wraps.

## Timing
- Edge E0 accepts a request.
- Save: Busy = 1 in cycles 1..8; words are written at edges E1..E8; IDLE and Busy = 0 from cycle 9. Next request is accepted at E9 at the earliest.
- Restore: addresses in cycles 1..8; data captured at E2..E9; WRITEBACK in cycle 10 (TRCWrite = 1); register file updated at E10; Busy = 0 from cycle 11.
- Busy rises combinationally in the cycle after acceptance, never in the accept cycle itself. Control holds the request until Busy is observed or one cycle passes.
- Reset values: state IDLE, Depth 0, Empty 1, Full 0, Busy 0, TRCWrite 0, tRegistersOut 0, Overflow 0, Underflow 0.
- Reset mid-operation: return to IDLE next edge. A partial frame is discarded and Depth is not changed by it. A pending WRITEBACK is cancelled, so TRCWrite is never asserted on the reset edge. RAM contents are don't-care.

## Configuration
- `TRC_CLEAR_ON_SAVE_EN` defined:
  - After a successful SAVE, go to CLEAR for one cycle with `tRegistersOut` = 0 and TRCWrite = 1. This zeroes $8–$15 for the callee.
  - Busy stays high through CLEAR, so a Save occupies 9 busy cycles and the next request is accepted at E10.
- Undefined: SAVE returns directly to IDLE, and TRCWrite only ever fires for Restore.

## Structure
- Shared package `trc_pkg`:
  - state enum
  - `TRC_WORDS` = 8
  - frame width 256
  - word-select function (bits [255-32k -: 32])
- One sub-module: `trc_word_ram`, a DEPTH×8 × DW single-port RAM with a synchronous registered read. The parent instantiates it and owns all control.

## Test plan
- Reset, then Save with $8..$15 = 0x11..0x88 → Busy high for 8 cycles; Depth = 1, Empty = 0.
- After that Save, write $8 = 0xDEAD via the register file, then Restore → TRCWrite pulses once in cycle 10 with `tRegistersOut[255:224]` = 0x11; $8 is back to 0x11.
- Save DEPTH frames with distinct patterns, then one more Save → Full = 1, Overflow = 1, Depth = DEPTH. DEPTH Restores return the frames in LIFO order.
- Restore on Empty → Underflow = 1, no TRCWrite, Busy stays 0. Simultaneous Save + Restore in IDLE → Save only, Depth = 1.
- Assert Reset in cycle 5 of a Restore → next cycle: IDLE, Depth = 0, TRCWrite never high.
- With `TRC_CLEAR_ON_SAVE_EN`: Save → TRCWrite = 1 with `tRegistersOut` = 0 in cycle 9; $8..$15 read 0; a subsequent Restore recovers the original values.

Source files
------------

// File: rtl/trc_pkg.sv
// Shared types and helpers for the t-register context stack ($8..$15 save/restore).
package trc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSave,
        StRdFill,
        StWriteback,
        StClear
    } trc_state_e;

    localparam int unsigned TRC_WORDS = 8;
    localparam int unsigned FRAME_W   = 256;

    // Word k of a frame; word 0 is $8 in the top 32 bits.
    function automatic logic [31:0] trc_word(input logic [FRAME_W-1:0] frame,
                                             input logic [2:0] k);
        return frame[32 * (7 - int'(k)) +: 32];
    endfunction

endpackage

// File: rtl/trc_word_ram.sv
// Single-port word RAM holding DEPTH frames of TRC_WORDS words, registered read.
module trc_word_ram
    import trc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                                 clk,
    input  logic                                 we,
    input  logic [$clog2(DEPTH*TRC_WORDS)-1:0]   addr,
    input  logic [DW-1:0]                        wdata,
    output logic [DW-1:0]                        rdata
);

    logic [DW-1:0] mem [DEPTH*TRC_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/t_reg_context_stack.sv
// Save/restore engine for t-registers $8..$15 backed by a word RAM frame stack.
// Optional TRC_CLEAR_ON_SAVE_EN: zero $8..$15 with one TRCWrite after each save.
module t_reg_context_stack
    import trc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Save,
    input  logic                         Restore,
    input  logic [255:0]                 tRegistersIn,
    output logic [255:0]                 tRegistersOut,
    output logic                         TRCWrite,
    output logic                         Busy,
    output logic [$clog2(DEPTH+1)-1:0]   Depth,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int unsigned FW = $clog2(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH * TRC_WORDS);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    trc_state_e       state;
    logic [3:0]       cnt;
    logic [255:0]     snap;
    logic [255:0]     asm_frame;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_wdata;
    logic [DW-1:0]    ram_rdata;
    logic [FW-1:0]    wr_frame;
    logic [FW-1:0]    rd_frame;

    always_comb begin
        wr_frame  = FW'(Depth);
        rd_frame  = FW'(Depth - 1'b1);
        ram_we    = (state == StSave);
        ram_addr  = {(state == StSave) ? wr_frame : rd_frame, cnt[2:0]};
        ram_wdata = trc_word(snap, cnt[2:0]);
        Busy      = (state != StIdle);
        Full      = (Depth == CW'(DEPTH));
        Empty     = (Depth == '0);
    end

    trc_word_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= StIdle;
            cnt           <= '0;
            snap          <= '0;
            asm_frame     <= '0;
            tRegistersOut <= '0;
            TRCWrite      <= 1'b0;
            Depth         <= '0;
            Overflow      <= 1'b0;
            Underflow     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    // Save wins over a simultaneous Restore.
                    if (Save) begin
                        if (Full) begin
                            Overflow <= 1'b1;
                        end else begin
                            snap  <= tRegistersIn;
                            cnt   <= '0;
                            state <= StSave;
                        end
                    end else if (Restore) begin
                        if (Empty) begin
                            Underflow <= 1'b1;
                        end else begin
                            cnt   <= '0;
                            state <= StRdFill;
                        end
                    end
                end
                StSave: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        Depth <= Depth + 1'b1;
`ifdef TRC_CLEAR_ON_SAVE_EN
                        tRegistersOut <= '0;
                        TRCWrite      <= 1'b1;
                        state         <= StClear;
`else
                        state         <= StIdle;
`endif
                    end
                end
                StRdFill: begin
                    // Addresses go out at cnt 0..7; read data lags by one cycle.
                    cnt <= cnt + 4'd1;
                    if (cnt != 4'd0) begin
                        asm_frame <= {asm_frame[223:0], ram_rdata};
                    end
                    if (cnt == 4'd8) begin
                        tRegistersOut <= {asm_frame[223:0], ram_rdata};
                        TRCWrite      <= 1'b1;
                        state         <= StWriteback;
                    end
                end
                StWriteback: begin
                    TRCWrite <= 1'b0;
                    Depth    <= Depth - 1'b1;
                    state    <= StIdle;
                end
                StClear: begin
                    TRCWrite <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t_reg_context_stack.sv
// Self-checking bench for t_reg_context_stack: directed steps plus random traffic vs a queue model.
module tb_t_reg_context_stack;

    localparam int DEPTH = 4;
`ifdef TRC_CLEAR_ON_SAVE_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    localparam int SAVE_BUSY = CLEAR_EN ? 9 : 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Save = 1'b0;
    logic         Restore = 1'b0;
    logic [255:0] rf = '0;
    logic [255:0] tRegistersOut;
    logic         TRCWrite;
    logic         Busy;
    logic [2:0]   Depth;
    logic         Full;
    logic         Empty;
    logic         Overflow;
    logic         Underflow;

    t_reg_context_stack #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Save          (Save),
        .Restore       (Restore),
        .tRegistersIn  (rf),
        .tRegistersOut (tRegistersOut),
        .TRCWrite      (TRCWrite),
        .Busy          (Busy),
        .Depth         (Depth),
        .Full          (Full),
        .Empty         (Empty),
        .Overflow      (Overflow),
        .Underflow     (Underflow)
    );

    always #5 Clk = ~Clk;

    // Register-file write port: capture every strobe the block issues.
    logic [255:0] wb_data = '0;
    int           wb_cnt = 0;
    always @(posedge Clk) begin
        if (TRCWrite) begin
            wb_data <= tRegistersOut;
            wb_cnt  <= wb_cnt + 1;
        end
    end

    // Reference model: LIFO of frames plus sticky flags.
    logic [255:0] mq[$];
    bit           m_ov = 1'b0;
    bit           m_un = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rand_frame();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_status();
        chk("busy_idle", Busy, 1'b0);
        chk("depth", Depth, mq.size());
        chk("full", Full, mq.size() == DEPTH);
        chk("empty", Empty, mq.size() == 0);
        chk("overflow", Overflow, m_ov);
        chk("underflow", Underflow, m_un);
    endtask

    // One request in IDLE, followed through to IDLE again.
    task automatic op(input logic s, input logic r);
        logic [255:0] exp_frame;
        bit           acc_s;
        bit           acc_r;
        int           wb0;
        exp_frame = '0;
        acc_s = s && (mq.size() < DEPTH);
        acc_r = !s && r && (mq.size() > 0);
        if (s && !acc_s) m_ov = 1'b1;
        if (!s && r && mq.size() == 0) m_un = 1'b1;
        if (acc_s) mq.push_back(rf);
        if (acc_r) exp_frame = mq.pop_back();
        wb0 = wb_cnt;
        Save = s;
        Restore = r;
        @(negedge Clk);
        Save = 1'b0;
        Restore = 1'b0;
        if (acc_s) begin
            for (int c = 1; c <= SAVE_BUSY; c++) begin
                chk("save_busy", Busy, 1'b1);
                chk("save_trc", TRCWrite, CLEAR_EN && c == 9);
                if (CLEAR_EN && c == 9) chk("clear_out", tRegistersOut, '0);
                // Register-file traffic mid-save must not reach the frame.
                if (c == 3) rf = rand_frame();
                @(negedge Clk);
            end
            chk("save_wb_count", wb_cnt - wb0, CLEAR_EN ? 1 : 0);
            if (CLEAR_EN) begin
                chk("clear_rf", wb_data, '0);
                rf = wb_data;
            end
        end else if (acc_r) begin
            for (int c = 1; c <= 10; c++) begin
                chk("rest_busy", Busy, 1'b1);
                chk("rest_trc", TRCWrite, c == 10);
                if (c == 10) chk("rest_out", tRegistersOut, exp_frame);
                @(negedge Clk);
            end
            chk("rest_wb_count", wb_cnt - wb0, 1);
            chk("rest_rf", wb_data, exp_frame);
            rf = wb_data;
        end else begin
            chk("rej_trc", TRCWrite, 1'b0);
            chk("rej_wb_count", wb_cnt - wb0, 0);
        end
        chk_status();
    endtask

    initial begin
        int wb0;
        int sel;
        repeat (2) @(negedge Clk);
        chk("rst_depth", Depth, 0);
        chk("rst_empty", Empty, 1'b1);
        chk("rst_full", Full, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_trc", TRCWrite, 1'b0);
        chk("rst_out", tRegistersOut, '0);
        chk("rst_ov", Overflow, 1'b0);
        chk("rst_un", Underflow, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);

        // Known pattern, clobber $8, restore it.
        rf = {32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        op(1'b1, 1'b0);
        rf[255:224] = 32'hDEAD;
        op(1'b0, 1'b1);
        chk("restored_r8", rf[255:224], 32'h11);

        // Fill, overflow, drain LIFO.
        for (int i = 0; i < DEPTH; i++) begin
            rf = rand_frame();
            op(1'b1, 1'b0);
        end
        rf = rand_frame();
        op(1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1);

        // Underflow, then Save+Restore together.
        op(1'b0, 1'b1);
        rf = rand_frame();
        op(1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) rf = rand_frame();
            op(sel <= 1 || sel == 3, sel >= 2);
        end

        // Reset during cycle 5 of a restore.
        if (mq.size() == 0) begin
            rf = rand_frame();
            op(1'b1, 1'b0);
        end
        wb0 = wb_cnt;
        Restore = 1'b1;
        @(negedge Clk);
        Restore = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        mq.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        chk("mid_rst_trc", TRCWrite, 1'b0);
        chk_status();
        repeat (8) @(negedge Clk);
        chk("mid_rst_no_wb", wb_cnt - wb0, 0);
        chk_status();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
